// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : proc_pkg
//  Description : Shared step/opcode types and instruction field positions
//                for the 9-bit simple processor control unit.
//  Revision    : 1.0  initial release
// ============================================================================
package proc_pkg;

  // Control step counter values
  typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

  // Opcodes; 100..111 are illegal and execute as a two-cycle NOP
  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_ILL4 = 3'b100,
    OP_ILL5 = 3'b101,
    OP_ILL6 = 3'b110,
    OP_ILL7 = 3'b111
  } opcode_t;

  // Instruction word field positions
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;

endpackage
`default_nettype wire

// File: rtl/dec3to8.sv
`default_nettype none
// ============================================================================
//  Module      : dec3to8
//  Description : 3-to-8 one-hot decoder with enable; all-zero when disabled.
//  Revision    : 1.0  initial release
// ============================================================================
module dec3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] onehot
);

  // One-hot decode of sel, gated by en
  always_comb begin
    onehot = 8'b0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/proc_control.sv
`default_nettype none
// ============================================================================
//  Module      : proc_control
//  Description : T0-T3 step FSM and instruction decode for the 9-bit simple
//                processor. Drives bus source selects, load enables, AddSub
//                and Done; holds no data registers itself.
//  Revision    : 1.0  initial release
// ============================================================================
module proc_control
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,      // asynchronous, active-low
  input  logic       Run,
  input  logic [8:0] IR,
  output logic       IRin,
  output logic       R0in,
  output logic       R1in,
  output logic       R2in,
  output logic       R3in,
  output logic       R4in,
  output logic       R5in,
  output logic       R6in,
  output logic       R7in,
  output logic       Ain,
  output logic       Gin,
  output logic       R0out,
  output logic       R1out,
  output logic       R2out,
  output logic       R3out,
  output logic       R4out,
  output logic       R5out,
  output logic       R6out,
  output logic       R7out,
  output logic       Gout,
  output logic       Dinout,
  output logic       AddSub,
  output logic       Done
);

  step_t      state;
  step_t      state_next;
  opcode_t    opcode;
  logic [2:0] x_field;
  logic [2:0] y_field;
  logic [7:0] x_hot;
  logic [7:0] y_hot;
  logic [7:0] rin_vec;
  logic [7:0] rout_vec;

  // Per-step control strobes; register selection is applied after decode
  logic       x_in;
  logic       x_out;
  logic       y_out;
  logic       is_arith;

  assign opcode  = opcode_t'(IR[OP_MSB:OP_LSB]);
  assign x_field = IR[X_MSB:X_LSB];
  assign y_field = IR[Y_MSB:Y_LSB];

  // X selects both a load target and a bus source; Y only a bus source
  dec3to8 u_dec_x (
    .sel    (x_field),
    .en     (1'b1),
    .onehot (x_hot)
  );

  dec3to8 u_dec_y (
    .sel    (y_field),
    .en     (y_out),
    .onehot (y_hot)
  );

  // x_out and y_out are never active in the same step, so the OR stays one-hot
  assign rin_vec  = x_in  ? x_hot : 8'b0;
  assign rout_vec = (x_out ? x_hot : 8'b0) | y_hot;

  assign {R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in}         = rin_vec;
  assign {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = rout_vec;

  assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

  // Step register; reset forces T0 regardless of clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= T0;
    else      state <= state_next;
  end

  // Next-step and output decode; everything held at 0 while reset is low
  always_comb begin
    state_next = state;
    IRin       = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    Dinout     = 1'b0;
    AddSub     = 1'b0;
    Done       = 1'b0;
    x_in       = 1'b0;
    x_out      = 1'b0;
    y_out      = 1'b0;

    if (rst) begin
      case (state)
        T0: begin
          IRin = Run;
          if (Run) state_next = T1;
        end
        T1: begin
          state_next = T2;
          case (opcode)
            OP_MV: begin
              y_out = 1'b1;
              x_in  = 1'b1;
              Done  = 1'b1;
            end
            OP_MVI: begin
              Dinout = 1'b1;
              x_in   = 1'b1;
              Done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              x_out = 1'b1;
              Ain   = 1'b1;
            end
            default: Done = 1'b1;
          endcase
        end
        T2: begin
          state_next = T3;
          if (is_arith) begin
            y_out  = 1'b1;
            Gin    = 1'b1;
            AddSub = (opcode == OP_SUB);
          end else begin
            Done = 1'b1;
          end
        end
        default: begin
          if (is_arith) begin
            Gout = 1'b1;
            x_in = 1'b1;
          end
          Done = 1'b1;
        end
      endcase

      if (Done) state_next = T0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_proc_control
//  Description : Directed self-checking bench for proc_control with a small
//                behavioural datapath (IR, R0-R7, A, G, bus) around it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_proc_control;
  import proc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       Run;
  logic [8:0] din;
  logic [8:0] ir_q;
  logic       IRin, Ain, Gin, Gout, Dinout, AddSub, Done;
  logic       R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic       R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;

  logic [7:0] rin_v;
  logic [7:0] rout_v;
  logic [22:0] outs;
  logic [8:0] regs [8];
  logic [8:0] a_q;
  logic [8:0] g_q;
  logic [8:0] bus;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  proc_control dut (
    .clk(clk), .rst(rst), .Run(Run), .IR(ir_q),
    .IRin(IRin),
    .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .R4in(R4in), .R5in(R5in), .R6in(R6in), .R7in(R7in),
    .Ain(Ain), .Gin(Gin),
    .R0out(R0out), .R1out(R1out), .R2out(R2out), .R3out(R3out),
    .R4out(R4out), .R5out(R5out), .R6out(R6out), .R7out(R7out),
    .Gout(Gout), .Dinout(Dinout), .AddSub(AddSub), .Done(Done)
  );

  assign rin_v  = {R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign rout_v = {R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign outs   = {IRin, rin_v, Ain, Gin, rout_v, Gout, Dinout, AddSub, Done};

  // Datapath model: bus mux
  always_comb begin
    bus = 9'd0;
    for (int k = 0; k < 8; k++) if (rout_v[k]) bus = regs[k];
    if (Gout)   bus = g_q;
    if (Dinout) bus = din;
  end

  // Datapath model: registers (no reset, so values survive a control reset)
  always @(posedge clk) begin
    if (IRin) ir_q <= din;
    for (int k = 0; k < 8; k++) if (rin_v[k]) regs[k] <= bus;
    if (Ain) a_q <= bus;
    if (Gin) g_q <= AddSub ? (a_q - bus) : (a_q + bus);
  end

  function automatic logic [22:0] ev(input logic irin, input logic [7:0] rin,
                                     input logic ain, input logic gin,
                                     input logic [7:0] rout, input logic gout,
                                     input logic dinout, input logic addsub,
                                     input logic done);
    return {irin, rin, ain, gin, rout, gout, dinout, addsub, done};
  endfunction

  task automatic chk(input string tag, input logic [22:0] exp);
    total++;
    assert (outs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
    end
  endtask

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, apply inputs, then check invariants
  task automatic cyc(input logic run, input logic [8:0] d);
    logic [9:0] sel;
    @(negedge clk);
    Run = run;
    din = d;
    #1;
    sel = {rout_v, Gout, Dinout};
    total++;
    assert (($countones(sel) <= 1) === 1'b1) else begin
      bad++;
      $error("FAIL bus_onehot observed=%b expected=at_most_one", sel);
    end
    total++;
    assert ((Gin && Gout) === 1'b0) else begin
      bad++;
      $error("FAIL gin_gout observed=%b expected=0", Gin && Gout);
    end
  endtask

  localparam logic [22:0] ZERO  = 23'd0;
  localparam logic [22:0] FETCH = 23'h400000;

  initial begin
    for (int k = 0; k < 8; k++) regs[k] = 9'd0;
    a_q  = 9'd0;
    g_q  = 9'd0;
    ir_q = 9'd0;
    rst  = 1'b0;
    Run  = 1'b1;
    din  = 9'd0;

    // Reset held: outputs zero even with Run=1
    cyc(1'b1, 9'd0);
    chk("reset_outs", ZERO);
    total++;
    assert (dut.state === T0) else begin
      bad++; $error("FAIL reset_state observed=%0d expected=0", dut.state);
    end

    // Release with Run=0: idle for 5 cycles
    @(negedge clk); Run = 1'b0; rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 9'd0);
      chk("idle_outs", ZERO);
    end

    // mvi R0,#5
    cyc(1'b1, 9'b001_000_000); chk("mvi_t0", FETCH);
    cyc(1'b0, 9'd5);
    chk("mvi_t1", ev(1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
    cyc(1'b0, 9'd0); chk("mvi_after", ZERO);
    chk9("mvi_r0", regs[0], 9'd5);

    // mv R1,R0
    cyc(1'b1, 9'b000_001_000); chk("mv_t0", FETCH);
    cyc(1'b0, 9'd0);
    chk("mv_t1", ev(1'b0, 8'h02, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 9'd0); chk9("mv_r1", regs[1], 9'd5);

    // add R0,R1
    cyc(1'b1, 9'b010_000_001); chk("add_t0", FETCH);
    cyc(1'b0, 9'd0);
    chk("add_t1", ev(1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 9'd0);
    chk("add_t2", ev(1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 9'd0);
    chk("add_t3", ev(1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 9'd0); chk("add_after", ZERO);
    chk9("add_r0", regs[0], 9'd10);

    // sub R0,R1
    cyc(1'b1, 9'b011_000_001); chk("sub_t0", FETCH);
    cyc(1'b0, 9'd0);
    chk("sub_t1", ev(1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 9'd0);
    chk("sub_t2", ev(1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 9'd0);
    chk("sub_t3", ev(1'b0, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 9'd0); chk9("sub_r0", regs[0], 9'd5);

    // Illegal opcode: Done only in T1, registers untouched
    cyc(1'b1, 9'b111_010_011); chk("ill_t0", FETCH);
    cyc(1'b0, 9'd0); chk("ill_t1", ev(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 9'd0); chk("ill_after", ZERO);
    chk9("ill_r0", regs[0], 9'd5);
    chk9("ill_r1", regs[1], 9'd5);
    chk9("ill_r2", regs[2], 9'd0);

    // Run held high: mvi R2,#3 ; add R2,R2 (Run dropped in T2) ; mv R3,R2
    cyc(1'b1, 9'b001_010_000); chk("b2b_mvi_t0", FETCH);
    cyc(1'b1, 9'd3);
    chk("b2b_mvi_t1", ev(1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
    cyc(1'b1, 9'b010_010_010); chk("b2b_add_t0", FETCH);
    cyc(1'b1, 9'd0);
    chk("b2b_add_t1", ev(1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 9'd0);
    chk("b2b_add_t2", ev(1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0));
    cyc(1'b1, 9'd0);
    chk("b2b_add_t3", ev(1'b0, 8'h04, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1));
    cyc(1'b1, 9'b000_011_010); chk("b2b_mv_t0", FETCH);
    cyc(1'b0, 9'd0);
    chk("b2b_mv_t1", ev(1'b0, 8'h08, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 9'd0); chk("b2b_after", ZERO);
    chk9("b2b_r2", regs[2], 9'd6);
    chk9("b2b_r3", regs[3], 9'd6);

    // mv R3,R3: same register as source and target
    cyc(1'b1, 9'b000_011_011); chk("mvxx_t0", FETCH);
    cyc(1'b0, 9'd0);
    chk("mvxx_t1", ev(1'b0, 8'h08, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc(1'b0, 9'd0); chk9("mvxx_r3", regs[3], 9'd6);

    // Reset during add T2: outputs drop immediately, state back to T0
    cyc(1'b1, 9'b010_000_001); chk("rstmid_t0", FETCH);
    cyc(1'b0, 9'd0);
    cyc(1'b0, 9'd0);
    chk("rstmid_t2", ev(1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0));
    #2 rst = 1'b0;
    #1 chk("rstmid_async", ZERO);
    total++;
    assert (dut.state === T0) else begin
      bad++; $error("FAIL rstmid_state observed=%0d expected=0", dut.state);
    end
    cyc(1'b1, 9'd0); chk("rstmid_hold", ZERO);

    // Release with Run=1: first edge fetches mvi R4,#7
    @(negedge clk); rst = 1'b1; Run = 1'b1; din = 9'b001_100_000;
    #1 chk("rel_t0", FETCH);
    cyc(1'b0, 9'd7);
    chk("rel_t1", ev(1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
    cyc(1'b0, 9'd0);
    chk9("rel_r4", regs[4], 9'd7);
    chk9("rel_r0_kept", regs[0], 9'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/proc_control.md
# proc_control

Control unit for the 9-bit simple processor. Fetches an instruction word into the datapath's IR register when `Run` is asserted. Decodes the opcode and register fields and steps a T0–T3 counter FSM. Each cycle it drives the one-hot bus-source selects, register load enables, `AddSub` and `Done`. It sits beside the datapath in the processor top level; it holds no data registers of its own.

## Interface
Parameters:
- none (widths fixed by the 9-bit ISA: 3-bit opcode, 3-bit X field, 3-bit Y field)

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `Run` in 1: start request, sampled only in T0.
- `IR` in 9: instruction register contents from the datapath; `IR[8:6]`=opcode, `IR[5:3]`=X, `IR[2:0]`=Y.
- `IRin` out 1: load IR from `Din`.
- `R0in`..`R7in` out 1 each: register load enables.
- `Ain`, `Gin` out 1 each: A and G load enables.
- `R0out`..`R7out`, `Gout`, `Dinout` out 1 each: bus source selects.
- `AddSub` out 1: 0 = A+BUS, 1 = A−BUS.
- `Done` out 1: one-cycle pulse in the final step of each instruction.

## Operation
The state register holds T0, T1, T2 or T3. The next state is T0 on reset or whenever `Done`=1; otherwise it advances T0→T1 (only if `Run`=1), T1→T2, T2→T3.

Opcodes:
- 000 mv Rx,Ry: T1: RYout, RXin, Done.
- 001 mvi Rx,#D: T1: Dinout, RXin, Done. The immediate must be presented on `Din` during T1 by the instruction source.
- 010 add Rx,Ry: T1: RXout, Ain. T2: RYout, Gin, AddSub=0. T3: Gout, RXin, Done.
- 011 sub Rx,Ry: same as add, with AddSub=1 in T2.
- 100–111 are illegal: T1 asserts Done only, with no enables or selects. This acts as a 2-cycle NOP.

T0 behaviour: `IRin`=`Run`; all other outputs are 0.

Decode rules:
- Outputs are combinational from state, `IR` and (in T0) `Run`.
- At most one of {R0out..R7out, Gout, Dinout} may be 1 in any cycle; zero is allowed.
- Gin and Gout are never both 1.
- X=Y is legal: mv R3,R3 drives R3out and R3in together; add R2,R2 doubles R2.
- `Run` is ignored in T1–T3. Deasserting it mid-instruction does not abort.
- While `rst`=0, every output is 0 and the state is T0, independent of `clk`.

## Timing
- Reset values: all outputs 0; state T0.
- Latency from the T0 fetch cycle to the Done cycle inclusive:
  - mv, mvi, illegal: 2 cycles.
  - add, sub: 4 cycles.
- Fetch: IR loads on the rising edge that ends T0. Decode in T1 uses the new IR.
- Back-to-back: the cycle after Done is T0. If `Run` is still 1 there, the next fetch happens immediately, with no idle cycle.
- Reset mid-instruction: outputs drop to 0 asynchronously and the FSM restarts at T0. Datapath registers written before the reset keep their values; there is no rollback.
- Reset deassertion: the first edge with `rst`=1 in T0 with `Run`=1 performs a fetch.

## Structure
- Package `proc_pkg`:
  - `typedef enum logic [1:0] {T0,T1,T2,T3} step_t`
  - `typedef enum logic [2:0] {OP_MV,OP_MVI,OP_ADD,OP_SUB,...} opcode_t`
  - field-position localparams for opcode/X/Y.
- Sub-module `dec3to8`: 3-bit in, enable in, 8-bit one-hot out. Instantiate it twice, for X (Rin/Rout) and Y (Rout).
- One `always_ff` for the step register with async active-low reset. One `always_comb` for next state and output decode.

## Test plan
- Reset: in add T2, drive `rst`=0 → all outputs 0 within the same cycle, state T0. Release with `Run`=0 → outputs stay 0 for 5 cycles.
- mvi R0,#5: IR=001_000_000, Din=5 in T1 → T1 has Dinout=R0in=Done=1, other outputs 0; R0=5 afterwards.
- mv R1,R0: IR=000_001_000 → T1 has R0out=R1in=Done=1; R1=5.
- add R0,R1 with R0=R1=5:
  - T1: R0out, Ain.
  - T2: R1out, Gin, AddSub=0.
  - T3: Gout, R0in, Done.
  - Result: R0=10.
- sub R0,R1 with R0=10, R1=5 → same sequence with AddSub=1 in T2; R0=5. Then illegal IR=111_xxx_xxx → Done in T1, no enable or select asserted, registers unchanged.
- `Run` held at 1 across mvi, add, mv → each Done is followed directly by T0 with IRin=1. Toggle `Run` to 0 during add T2 → the instruction still completes in T3.
- Every cycle, all tests: assert bus-select one-hot-or-zero and never (Gin && Gout).
